wbs_timer: RTL
==============

# wbs_timer

Wishbone slave peripheral that terminates the MCU's 32-bit Wishbone master bus and replaces the loopback stub. It provides a prescaled 32-bit timer with compare and auto-reload, a level interrupt output, an optional GPIO port, and a constant ID register. Each access is acknowledged with a single-cycle registered ack.

## Interface
Parameters:
- `GPIO_W`, default 8: GPIO port width, 1..32.
- `ID`, default 32'h7137_0001: value returned by the ID register.

Ports (clock and reset first):
- `clk`  in  1: system clock.
- `p_reset_n`  in  1: reset, asynchronous, active-low.
- `adr_i`  in  15: word address. Only `adr_i[2:0]` is decoded; upper bits are ignored.
- `dat_i`  in  32: write data, from the master's `dat_o`.
- `dat_o`  out  32: read data, to the master's `dat_i`.
- `we_i`  in  1: write enable.
- `stb_i`  in  1: strobe. Held by the master until ack.
- `ack_o`  out  1: acknowledge, one-cycle pulse.
- `irq_o`  out  1: timer interrupt, level.
- `gpio_i`  in  GPIO_W: asynchronous GPIO inputs.
- `gpio_o`  out  GPIO_W: GPIO outputs.

## Operation
Register map by `adr_i[2:0]`:
- 0 CTRL, R/W [2:0]: bit0 EN, bit1 RELOAD, bit2 IE.
- 1 PRESCALE, R/W [15:0].
- 2 COMPARE, R/W [31:0].
- 3 COUNT, R/W [31:0]. A write loads the counter and clears the prescaler.
- 4 STATUS [0] MATCH. Write 1 to clear; writing 0 has no effect.
- 5 GPIO_OUT, R/W [GPIO_W-1:0].
- 6 GPIO_IN, read-only: the synchronized value of `gpio_i`.
- 7 ID, read-only.

Unused register bits read 0. Writes to read-only registers are ignored.

Bus behaviour:
- An access is accepted on any edge where `stb_i` is 1 and `ack_o` is 0.
- The write takes effect on that same edge.
- On that edge `ack_o` is set to 1 and `dat_o` is loaded with the register value as it was before the edge.
- Next edge: `ack_o` returns to 0.
- If `stb_i` is held high continuously, the block acks every second cycle and performs one access per ack.
- `dat_o` holds its value between accesses.

Timer behaviour:
- When EN is 1, the prescaler counts 0..PRESCALE. When it reaches PRESCALE it produces a tick and returns to 0. PRESCALE = 0 gives a tick every cycle.
- On each tick, COUNT increments and wraps at 2^32.
- MATCH is set on a tick where COUNT equals COMPARE, with COUNT evaluated before the increment.
- On that matching tick, if RELOAD is 1, COUNT loads 0 instead of incrementing.
- When EN is 0, the prescaler and COUNT freeze at their current values.
- `irq_o` = MATCH & IE.

Simultaneous events:
- A bus write to COUNT on the same edge as a tick: the write wins, and the prescaler goes to 0.
- A STATUS W1C on the same edge as a new match: the set wins.
- A CTRL write that clears EN takes effect on that edge, so no tick occurs on the same edge.

## Timing
- Reset values:
  - `ack_o` = 0, `dat_o` = 0, `irq_o` = 0, `gpio_o` = 0.
  - CTRL = 0, PRESCALE = 0, COMPARE = 32'hFFFF_FFFF, COUNT = 0, MATCH = 0.
  - Prescaler = 0; synchronizer flops = 0.
- Access latency: `ack_o` rises 1 cycle after `stb_i` is first sampled high. Read data is valid in the same cycle as `ack_o`.
- `gpio_i` passes through a 2-flop synchronizer, so GPIO_IN lags the pin by 2 to 3 cycles.
- With EN set and PRESCALE = P, COUNT advances once every P+1 cycles. The first tick occurs P+1 cycles after the write that sets EN.
- MATCH, and hence `irq_o`, rises on the edge of the matching tick.
- Reset asserted mid-access: `ack_o` drops immediately and all registers return to their reset values. The master must abandon the cycle.

## Configuration
- Macro: `WBS_GPIO_EN`.
- Defined: GPIO_OUT and GPIO_IN are implemented as described.
- Not defined:
  - Addresses 5 and 6 read 0 and ignore writes.
  - `gpio_o` is tied to 0, `gpio_i` is unused, and no synchronizer flops exist.
  - Accesses to those addresses are still acked normally.

## Test plan
- Reset, then read all 8 addresses -> values 0, 0, FFFF_FFFF, 0, 0, 0, 0, ID. Each `ack_o` is exactly one cycle wide and arrives 1 cycle after `stb_i`.
- Write PRESCALE = 3, COMPARE = 5, CTRL = 7 -> MATCH and `irq_o` rise 24 cycles after the CTRL write. COUNT then restarts from 0.
- With RELOAD = 0 and COMPARE = 2: write COUNT = FFFF_FFFE, PRESCALE = 0, EN = 1 -> COUNT wraps to 0 after 2 ticks, and MATCH sets on the tick where COUNT = 2.
- Hold `stb_i` high across 3 writes to GPIO_OUT with values 01, 02, 03 -> acks occur on alternate cycles and `gpio_o` ends at 03. Drive `gpio_i` = A5 -> GPIO_IN reads A5 within 3 cycles (with `WBS_GPIO_EN`); without the macro it reads 0.
- Issue the STATUS W1C on the same edge as a matching tick -> MATCH stays 1. A COUNT write coincident with a tick -> the written value wins.
- Assert `p_reset_n` low during an outstanding ack with the timer running -> all outputs are 0 at once, and after release the register readback equals the reset values.

Source files
------------

// File: rtl/wbs_timer.sv
// wbs_timer: Wishbone slave with a prescaled 32-bit timer (compare, auto-reload,
// level interrupt), an optional GPIO port and a constant ID register.
// Define WBS_GPIO_EN to build GPIO_OUT/GPIO_IN. Without it, addresses 5 and 6
// read 0 and ignore writes, and gpio_o is tied low.
module wbs_timer #(
   parameter int unsigned GPIO_W = 8,
   parameter logic [31:0] ID     = 32'h7137_0001
) (
   input  logic              clk,
   input  logic              p_reset_n,
   input  logic [14:0]       adr_i,
   input  logic [31:0]       dat_i,
   output logic [31:0]       dat_o,
   input  logic              we_i,
   input  logic              stb_i,
   output logic              ack_o,
   output logic              irq_o,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o
);

   localparam logic [2:0] A_CTRL  = 3'd0;
   localparam logic [2:0] A_PRESC = 3'd1;
   localparam logic [2:0] A_CMP   = 3'd2;
   localparam logic [2:0] A_CNT   = 3'd3;
   localparam logic [2:0] A_STAT  = 3'd4;
   localparam logic [2:0] A_GOUT  = 3'd5;
   localparam logic [2:0] A_GIN   = 3'd6;

   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] presc_q, presc_d;
   logic [31:0] cmp_q, cmp_d;
   logic [31:0] cnt_q, cnt_d;
   logic        match_q, match_d;
   logic [15:0] pre_q, pre_d;

   logic        acc, wr, tick;
   logic [31:0] rdata, rd_gout, rd_gin;

   // Only the low three address bits select a register.
   logic        unused_adr;
   assign unused_adr = ^adr_i[14:3];

   // One access per ack: a held strobe is accepted only while ack is low.
   assign acc   = stb_i & ~ack_q;
   assign wr    = acc & we_i;
   assign ack_o = ack_q;
   assign dat_o = dat_q;
   assign irq_o = match_q & ctrl_q[2];

`ifdef WBS_GPIO_EN
   logic [GPIO_W-1:0] gout_q, gout_d;
   logic [GPIO_W-1:0] sync1_q, sync2_q;

   assign gout_d = (wr && adr_i[2:0] == A_GOUT) ? dat_i[GPIO_W-1:0] : gout_q;
   assign gpio_o = gout_q;

   // GPIO output register and two-flop synchronizer for the async inputs
   always_ff @(posedge clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         gout_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         gout_q  <= gout_d;
         sync1_q <= gpio_i;
         sync2_q <= sync1_q;
      end
   end

   // Zero-extend GPIO values onto the 32-bit read bus
   always_comb begin
      rd_gout               = '0;
      rd_gout[GPIO_W-1:0]   = gout_q;
      rd_gin                = '0;
      rd_gin[GPIO_W-1:0]    = sync2_q;
   end
`else
   logic unused_gpio;
   assign unused_gpio = ^gpio_i;
   assign gpio_o      = '0;
   assign rd_gout     = '0;
   assign rd_gin      = '0;
`endif

   // Read mux over the register values as they stand before the edge
   always_comb begin
      rdata = '0;
      case (adr_i[2:0])
         A_CTRL:  rdata[2:0]  = ctrl_q;
         A_PRESC: rdata[15:0] = presc_q;
         A_CMP:   rdata       = cmp_q;
         A_CNT:   rdata       = cnt_q;
         A_STAT:  rdata[0]    = match_q;
         A_GOUT:  rdata       = rd_gout;
         A_GIN:   rdata       = rd_gin;
         default: rdata       = ID;
      endcase
   end

   // Next state for bus handshake, control registers, prescaler and counter
   always_comb begin
      ack_d   = acc;
      dat_d   = acc ? rdata : dat_q;
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      cmp_d   = cmp_q;
      cnt_d   = cnt_q;
      match_d = match_q;
      pre_d   = pre_q;
      tick    = 1'b0;

      if (wr) begin
         case (adr_i[2:0])
            A_CTRL:  ctrl_d  = dat_i[2:0];
            A_PRESC: presc_d = dat_i[15:0];
            A_CMP:   cmp_d   = dat_i;
            A_STAT:  if (dat_i[0]) match_d = 1'b0;
            default: ;
         endcase
      end

      // Setting EN starts counting on the next edge; clearing it stops at once.
      if (ctrl_q[0] && ctrl_d[0]) begin
         if (pre_q >= presc_q) begin
            tick  = 1'b1;
            pre_d = '0;
         end else begin
            pre_d = pre_q + 16'd1;
         end
      end

      // A new match overrides a simultaneous W1C.
      if (tick) begin
         if (cnt_q == cmp_q) begin
            match_d = 1'b1;
            cnt_d   = ctrl_q[1] ? 32'd0 : cnt_q + 32'd1;
         end else begin
            cnt_d   = cnt_q + 32'd1;
         end
      end

      // A bus load of COUNT beats a coincident tick.
      if (wr && adr_i[2:0] == A_CNT) begin
         cnt_d = dat_i;
         pre_d = '0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         ack_q   <= 1'b0;
         dat_q   <= '0;
         ctrl_q  <= '0;
         presc_q <= '0;
         cmp_q   <= 32'hFFFF_FFFF;
         cnt_q   <= '0;
         match_q <= 1'b0;
         pre_q   <= '0;
      end else begin
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         cmp_q   <= cmp_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         pre_q   <= pre_d;
      end
   end

endmodule
